// File: rtl/led_fade_sequencer_pkg.sv
// ============================================================================
// Module : led_fade_pkg
// Brief  : Shared state encoding and default widths for the LED fade sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package led_fade_pkg;

    localparam int DUTY_W_DEF = 8;
    localparam int DIV_W_DEF  = 16;
    localparam int HOLD_W_DEF = 16;
    localparam int PHASE_W    = 3;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_UP     = 3'd1,
        ST_HOLD_H = 3'd2,
        ST_DOWN   = 3'd3,
        ST_HOLD_L = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/led_fade_sequencer_step_prescaler.sv
// ============================================================================
// Module : step_prescaler
// Brief  : Divide-by-div clock enable; one-cycle tick when cnt reaches div-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module step_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             at_end;

    // div is never 0 here: the caller substitutes 1 when latching
    assign at_end = (cnt == div - DIV_W'(1));
    assign tick   = !clear && at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_fade_sequencer.sv
// ============================================================================
// Module : led_fade_sequencer
// Brief  : Breathing-LED sequencer: ramp up, hold, ramp down, hold, with PWM out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_fade_sequencer
    import led_fade_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               loop_i,
    input  logic [DIV_W-1:0]   step_div_i,
    input  logic [HOLD_W-1:0]  hold_i,
    input  logic [DUTY_W-1:0]  max_duty_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic [DUTY_W-1:0]  duty_o,
    output logic               pwm_o
);

    state_t              state;
    logic [DUTY_W-1:0]   duty;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic [DUTY_W-1:0]   max_lat;
    logic [DIV_W-1:0]    div_lat;
    logic [HOLD_W-1:0]   hold_lat;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                loop_lat;
    logic                busy;
    logic                done;
    logic                pwm;

    logic                tick;
    logic                hold_last;
    logic [DUTY_W-1:0]   duty_inc;

    step_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clear (state == ST_IDLE),
        .div   (div_lat),
        .tick  (tick)
    );

    // A hold of 0 behaves like a hold of 1: leave on the first tick
    assign hold_last = (hold_lat == '0) || (hold_cnt == hold_lat - HOLD_W'(1));
    assign duty_inc  = duty + DUTY_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            duty     <= '0;
            pwm_cnt  <= '0;
            max_lat  <= '0;
            div_lat  <= '0;
            hold_lat <= '0;
            hold_cnt <= '0;
            loop_lat <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            done    <= 1'b0;
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            pwm     <= (pwm_cnt < duty);
            if (state != ST_IDLE && stop_i) begin
                state    <= ST_IDLE;
                duty     <= '0;
                hold_cnt <= '0;
                busy     <= 1'b0;
                pwm      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i && !stop_i) begin
                            div_lat  <= (step_div_i == '0) ? DIV_W'(1) : step_div_i;
                            hold_lat <= hold_i;
                            max_lat  <= max_duty_i;
                            loop_lat <= loop_i;
                            duty     <= '0;
                            state    <= ST_UP;
                            busy     <= 1'b1;
                        end
                    end
                    ST_UP: begin
                        if (tick) begin
                            if (max_lat == '0) begin
                                state    <= ST_HOLD_H;
                                hold_cnt <= '0;
                            end else begin
                                duty <= duty_inc;
                                if (duty_inc == max_lat) begin
                                    state    <= ST_HOLD_H;
                                    hold_cnt <= '0;
                                end
                            end
                        end
                    end
                    ST_HOLD_H: begin
                        if (tick) begin
                            if (hold_last) state <= ST_DOWN;
                            else           hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    ST_DOWN: begin
                        if (tick) begin
                            if (duty <= DUTY_W'(1)) begin
                                duty     <= '0;
                                state    <= ST_HOLD_L;
                                hold_cnt <= '0;
                            end else begin
                                duty <= duty - DUTY_W'(1);
                            end
                        end
                    end
                    ST_HOLD_L: begin
                        if (tick) begin
                            if (!hold_last) begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end else if (loop_lat) begin
                                state <= ST_UP;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        duty  <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o  = busy;
    assign done_o  = done;
    assign phase_o = state;
    assign duty_o  = duty;
    assign pwm_o   = pwm;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_sequencer.sv
// ============================================================================
// Module : tb_led_fade_sequencer
// Brief  : Self-checking bench; expected per-cycle timeline built from phase durations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_fade_sequencer;

    localparam int DUTY_W = 8;
    localparam int DIV_W  = 16;
    localparam int HOLD_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_in = 1'b0;
    logic [DIV_W-1:0]  step_div = '0;
    logic [HOLD_W-1:0] hold = '0;
    logic [DUTY_W-1:0] max_duty = '0;
    logic              busy, done, pwm;
    logic [2:0]        phase;
    logic [DUTY_W-1:0] duty;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic [7:0] du;
        logic       bz;
        logic       dn;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    led_fade_sequencer #(
        .DUTY_W (DUTY_W),
        .DIV_W  (DIV_W),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .stop_i     (stop),
        .loop_i     (loop_in),
        .step_div_i (step_div),
        .hold_i     (hold),
        .max_duty_i (max_duty),
        .busy_o     (busy),
        .done_o     (done),
        .phase_o    (phase),
        .duty_o     (duty),
        .pwm_o      (pwm)
    );

    function automatic void push_n(int n, logic [2:0] ph, int du, logic bz, logic dn);
        logic [31:0] d32 = du;
        for (int i = 0; i < n; i++) q.push_back('{ph, d32[7:0], bz, dn});
    endfunction

    // One breathing period expressed as phase durations in clock cycles
    function automatic void build_period(int div, int hd, int mx);
        int d = (div == 0) ? 1 : div;
        int h = (hd == 0) ? 1 : hd;
        if (mx == 0) push_n(d, 3'd1, 0, 1'b1, 1'b0);
        else for (int k = 0; k < mx; k++) push_n(d, 3'd1, k, 1'b1, 1'b0);
        push_n(h * d, 3'd2, mx, 1'b1, 1'b0);
        if (mx == 0) push_n(d, 3'd3, 0, 1'b1, 1'b0);
        else for (int k = mx; k > 0; k--) push_n(d, 3'd3, k, 1'b1, 1'b0);
        push_n(h * d, 3'd4, 0, 1'b1, 1'b0);
    endfunction

    function automatic void push_done();
        push_n(1, 3'd0, 0, 1'b0, 1'b1);
        push_n(1, 3'd0, 0, 1'b0, 1'b0);
    endfunction

    task automatic do_start(int div, int hd, int mx, logic lp);
        @(negedge clk);
        step_div = div[DIV_W-1:0];
        hold     = hd[HOLD_W-1:0];
        max_duty = mx[DUTY_W-1:0];
        loop_in  = lp;
        start    = 1'b1;
    endtask

    // Checks every queued cycle; optionally scrambles start/config while busy
    task automatic check_queue(string name, bit scramble);
        exp_t e, got;
        int   idx = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            e   = q.pop_front();
            got = '{phase, duty, busy, done};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got ph=%0d duty=%0d busy=%0b done=%0b, expected ph=%0d duty=%0d busy=%0b done=%0b",
                         name, idx, got.ph, got.du, got.bz, got.dn, e.ph, e.du, e.bz, e.dn);
            end
            idx++;
            if (scramble && q.size() > 1) begin
                start    = 1'($urandom);
                step_div = DIV_W'($urandom);
                hold     = HOLD_W'($urandom);
                max_duty = DUTY_W'($urandom);
                loop_in  = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start   = 1'b0;
        loop_in = 1'b0;
    endtask

    task automatic test_reset();
        int waited = 0;
        #3;
        n_cmp++;
        if ({busy, done, phase, duty, pwm} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_initial: got %b, expected all zero", {busy, done, phase, duty, pwm});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start(3, 1, 10, 1'b0);
        @(negedge clk);
        start = 1'b0;
        while (duty != 8'd5 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (duty != 8'd5) begin
            n_bad++;
            $display("FAIL reset_wait_duty5: got duty=%0d, expected 5 within 200 cycles", duty);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, phase, duty, pwm} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_async: got %b, expected all zero", {busy, done, phase, duty, pwm});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (phase !== 3'd0 || busy !== 1'b0 || duty !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_release: got ph=%0d busy=%0b duty=%0d, expected IDLE", phase, busy, duty);
        end
    endtask

    task automatic test_spec_sequence();
        do_start(10, 2, 4, 1'b0);
        build_period(10, 2, 4);
        push_done();
        check_queue("spec_seq", 1'b0);
    endtask

    task automatic test_minimal();
        do_start(0, 0, 0, 1'b0);
        build_period(0, 0, 0);
        push_done();
        check_queue("minimal", 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int div = $urandom_range(0, 4);
            int hd  = $urandom_range(0, 3);
            int mx  = $urandom_range(0, 7);
            do_start(div, hd, mx, 1'b0);
            build_period(div, hd, mx);
            push_done();
            check_queue($sformatf("random%0d_d%0d_h%0d_m%0d", r, div, hd, mx), 1'b1);
        end
    endtask

    task automatic test_loop_stop();
        do_start(2, 1, 3, 1'b1);
        build_period(2, 1, 3);
        build_period(2, 1, 3);
        push_n(2, 3'd1, 0, 1'b1, 1'b0);
        push_n(1, 3'd1, 1, 1'b1, 1'b0);
        check_queue("loop", 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++;
        if ({phase, duty, busy, done, pwm} !== 14'd0) begin
            n_bad++;
            $display("FAIL loop_stop: got ph=%0d duty=%0d busy=%0b done=%0b pwm=%0b, expected all zero",
                     phase, duty, busy, done, pwm);
        end
    endtask

    task automatic pwm_count(string name, int mx, int exp_hi);
        int hi = 0;
        if (mx >= 0) begin
            do_start(1, 700, mx, 1'b0);
            @(negedge clk);
            start = 1'b0;
            repeat (300) @(negedge clk);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        n_cmp++;
        if (hi != exp_hi) begin
            n_bad++;
            $display("FAIL %s: got %0d high cycles of 256, expected %0d", name, hi, exp_hi);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic test_pwm();
        pwm_count("pwm_duty64", 64, 64);
        pwm_count("pwm_duty255", 255, 255);
        pwm_count("pwm_idle_duty0", -1, 0);
    endtask

    task automatic test_start_stop_idle();
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (busy !== 1'b0 || phase !== 3'd0) begin
                n_bad++;
                $display("FAIL start_stop_idle: got busy=%0b ph=%0d, expected busy=0 ph=0", busy, phase);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_spec_sequence();
        test_minimal();
        test_random();
        test_loop_stop();
        test_pwm();
        test_start_stop_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
